store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 111 +++++++++++
 tb/tb_store_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of word-addressed stores drained to data memory,
// with full and load-RAW stalls. Define STORE_MERGE_EN to enable tail merging.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_wdata,
  input  logic [3:0]               st_byteen,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     stall,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_byteen,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic   [DEPTH-1:0] vld_q, vld_d;
  logic   [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic   [CW-1:0]    count_q, count_d;
  logic   [DEPTH-1:0] raw_vec;
  logic               st_act, full, merge, push, pop;
  entry_t             head;
  logic               unused_bits;

  assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_act = st_valid && (st_byteen != 4'b0000);
  assign full   = (count_q == CW'(DEPTH));

`ifdef STORE_MERGE_EN
  logic [PW-1:0] tail_idx;
  assign tail_idx = wr_ptr_q - PW'(1);
  // count>=2 guarantees the tail is never the head under handshake
  assign merge = st_act && (count_q >= CW'(2)) && (ent_q[tail_idx].waddr == st_addr[31:2]);
`else
  assign merge = 1'b0;
`endif

  assign push = st_act && !full && !merge;
  assign pop  = (count_q != '0) && mem_ack;

  for (genvar i = 0; i < DEPTH; i++) begin : g_raw
    assign raw_vec[i] = vld_q[i] && (ent_q[i].waddr == ld_addr[31:2]);
  end

  // a same-cycle pop does not free a slot for the stalled store
  assign stall = (st_act && full && !merge) || (ld_valid && (|raw_vec));

  always_comb begin
    ent_d    = ent_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push) begin
      ent_d[wr_ptr_q] = '{waddr: st_addr[31:2], data: st_wdata, be: st_byteen};
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
`ifdef STORE_MERGE_EN
    if (merge) begin
      for (int b = 0; b < 4; b++)
        if (st_byteen[b]) ent_d[tail_idx].data[8*b +: 8] = st_wdata[8*b +: 8];
      ent_d[tail_idx].be = ent_q[tail_idx].be | st_byteen;
    end
`endif
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (reset) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head       = ent_q[rd_ptr_q];
  assign mem_req    = (count_q != '0);
  assign mem_addr   = mem_req ? {head.waddr, 2'b00} : 32'h0;
  assign mem_wdata  = mem_req ? head.data : 32'h0;
  assign mem_byteen = mem_req ? head.be : 4'h0;
  assign count      = count_q;
  assign empty      = (count_q == '0);
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed table, merge sequence and
// randomized traffic against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, st_valid, ld_valid, mem_ack;
  logic [31:0] st_addr, st_wdata, ld_addr;
  logic [3:0]  st_byteen;
  logic        stall, mem_req, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic [$clog2(DEPTH):0] count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_byteen(st_byteen), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_ack(mem_ack),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
  } ment_t;
  ment_t q[$];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_merge();
    bit m = 1'b0;
`ifdef STORE_MERGE_EN
    int n = q.size();
    if (st_valid && st_byteen != 4'b0 && n >= 2)
      m = (q[n-1].wa == st_addr[31:2]);
`endif
    return m;
  endfunction

  task automatic model_check();
    int  n = q.size();
    bit  act = st_valid && (st_byteen != 4'b0);
    bit  mrg = model_merge();
    bit  hit = 1'b0;
    foreach (q[i]) if (ld_valid && q[i].wa == ld_addr[31:2]) hit = 1'b1;
    chk("m_stall", 32'(stall), 32'((act && n == DEPTH && !mrg) || hit));
    chk("m_mem_req", 32'(mem_req), 32'(n > 0));
    chk("m_mem_addr", mem_addr, (n > 0) ? {q[0].wa, 2'b00} : 32'h0);
    chk("m_mem_wdata", mem_wdata, (n > 0) ? q[0].d : 32'h0);
    chk("m_mem_byteen", 32'(mem_byteen), (n > 0) ? 32'(q[0].be) : 32'h0);
    chk("m_count", 32'(count), 32'(n));
    chk("m_empty", 32'(empty), 32'(n == 0));
  endtask

  task automatic model_update();
    int n = q.size();
    bit act = st_valid && (st_byteen != 4'b0);
    bit mrg = model_merge();
    bit pop = (n > 0) && mem_ack;
    bit acc = act && !mrg && (n < DEPTH);
    if (reset) begin
      q.delete();
      return;
    end
    if (mrg) begin
      ment_t t = q[n-1];
      for (int b = 0; b < 4; b++)
        if (st_byteen[b]) t.d[8*b +: 8] = st_wdata[8*b +: 8];
      t.be = t.be | st_byteen;
      q[n-1] = t;
    end
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{wa: st_addr[31:2], d: st_wdata, be: st_byteen});
  endtask

  task automatic apply(input logic r, input logic stv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic [3:0] sbe, input logic ldv,
                       input logic [31:0] la, input logic ak);
    @(negedge clk);
    reset = r; st_valid = stv; st_addr = sa; st_wdata = sd; st_byteen = sbe;
    ld_valid = ldv; ld_addr = la; mem_ack = ak;
    #1;
    if (chk_en) model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  typedef struct {
    logic        r, stv;
    logic [31:0] sa, sd;
    logic [3:0]  sbe;
    logic        ldv;
    logic [31:0] la;
    logic        ak;
    logic        e_stall, e_req;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_be;
    logic [2:0]  e_cnt;
  } vec_t;

  function automatic vec_t v(input logic r, input logic stv, input logic [31:0] sa,
                             input logic [31:0] sd, input logic [3:0] sbe, input logic ldv,
                             input logic [31:0] la, input logic ak, input logic es,
                             input logic er, input logic [31:0] ea, input logic [31:0] ed,
                             input logic [3:0] eb, input logic [2:0] ec);
    vec_t x;
    x.r = r; x.stv = stv; x.sa = sa; x.sd = sd; x.sbe = sbe; x.ldv = ldv; x.la = la;
    x.ak = ak; x.e_stall = es; x.e_req = er; x.e_addr = ea; x.e_data = ed;
    x.e_be = eb; x.e_cnt = ec;
    return x;
  endfunction

  vec_t tbl[18];

  initial begin
    logic [31:0] sa, la;
    // expected outputs are the combinational values seen with the row's inputs applied
    tbl[0]  = v(0,0,32'h00,32'h0,4'h0,0,32'h0,0, 0,0,32'h00,32'h0,4'h0,3'd0);
    tbl[1]  = v(0,1,32'h10,32'hAABBCCDD,4'hF,0,32'h0,0, 0,0,32'h00,32'h0,4'h0,3'd0);
    tbl[2]  = v(0,0,32'h00,32'h0,4'h0,0,32'h0,0, 0,1,32'h10,32'hAABBCCDD,4'hF,3'd1);
    tbl[3]  = v(0,1,32'h20,32'h2,4'h3,0,32'h0,0, 0,1,32'h10,32'hAABBCCDD,4'hF,3'd1);
    tbl[4]  = v(0,1,32'h30,32'h3,4'hF,0,32'h0,0, 0,1,32'h10,32'hAABBCCDD,4'hF,3'd2);
    tbl[5]  = v(0,1,32'h40,32'h4,4'hF,0,32'h0,0, 0,1,32'h10,32'hAABBCCDD,4'hF,3'd3);
    tbl[6]  = v(0,1,32'h50,32'h5,4'hF,0,32'h0,0, 1,1,32'h10,32'hAABBCCDD,4'hF,3'd4);
    tbl[7]  = v(0,1,32'h50,32'h5,4'hF,0,32'h0,1, 1,1,32'h10,32'hAABBCCDD,4'hF,3'd4);
    tbl[8]  = v(0,1,32'h50,32'h5,4'hF,0,32'h0,0, 0,1,32'h20,32'h2,4'h3,3'd3);
    tbl[9]  = v(0,0,32'h00,32'h0,4'h0,0,32'h0,0, 0,1,32'h20,32'h2,4'h3,3'd4);
    tbl[10] = v(0,1,32'h60,32'h6,4'h0,0,32'h0,0, 0,1,32'h20,32'h2,4'h3,3'd4);
    tbl[11] = v(0,0,32'h00,32'h0,4'h0,0,32'h0,0, 0,1,32'h20,32'h2,4'h3,3'd4);
    tbl[12] = v(0,0,32'h00,32'h0,4'h0,1,32'h23,0, 1,1,32'h20,32'h2,4'h3,3'd4);
    tbl[13] = v(0,0,32'h00,32'h0,4'h0,1,32'h24,0, 0,1,32'h20,32'h2,4'h3,3'd4);
    tbl[14] = v(0,0,32'h00,32'h0,4'h0,1,32'h33,0, 1,1,32'h20,32'h2,4'h3,3'd4);
    tbl[15] = v(1,0,32'h00,32'h0,4'h0,0,32'h0,1, 0,1,32'h20,32'h2,4'h3,3'd4);
    tbl[16] = v(0,0,32'h00,32'h0,4'h0,0,32'h0,1, 0,0,32'h00,32'h0,4'h0,3'd0);
    tbl[17] = v(0,0,32'h00,32'h0,4'h0,0,32'h0,0, 0,0,32'h00,32'h0,4'h0,3'd0);

    // bring the DUT out of its unknown power-up state
    apply(1,0,0,0,0,0,0,0); tick();
    apply(1,0,0,0,0,0,0,0); tick();
    chk_en = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].r, tbl[i].stv, tbl[i].sa, tbl[i].sd, tbl[i].sbe,
            tbl[i].ldv, tbl[i].la, tbl[i].ak);
      chk($sformatf("row%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d_req", i), 32'(mem_req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_data", i), mem_wdata, tbl[i].e_data);
      chk($sformatf("row%0d_be", i), 32'(mem_byteen), 32'(tbl[i].e_be));
      chk($sformatf("row%0d_cnt", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d_empty", i), 32'(empty), 32'(tbl[i].e_cnt == 3'd0));
      tick();
    end

    // tail merge sequence: 0x40, 0x80, then a partial store to the 0x80 word
    apply(0,1,32'h40,32'h11,4'h1,0,0,0); tick();
    apply(0,1,32'h80,32'h11,4'h1,0,0,0); tick();
    apply(0,1,32'h82,32'h00220000,4'h4,0,0,0);
    chk("merge_stall", 32'(stall), 32'h0);
    tick();
    apply(0,0,0,0,0,0,0,0);
`ifdef STORE_MERGE_EN
    chk("merge_count", 32'(count), 32'd2);
`else
    chk("merge_count", 32'(count), 32'd3);
`endif
    tick();
    apply(0,0,0,0,0,0,0,1); tick();
    apply(0,0,0,0,0,0,0,0);
    chk("merge_head_addr", mem_addr, 32'h80);
`ifdef STORE_MERGE_EN
    chk("merge_head_be", 32'(mem_byteen), 32'h5);
    chk("merge_head_data", mem_wdata, 32'h00220011);
`else
    chk("merge_head_be", 32'(mem_byteen), 32'h1);
    chk("merge_head_data", mem_wdata, 32'h00000011);
`endif
    tick();
    apply(1,0,0,0,0,0,0,1); tick();

    // randomized traffic over a small address pool to provoke RAW hits and fulls
    for (int c = 0; c < 600; c++) begin
      sa = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      la = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), sa, $urandom,
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), la,
            ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
